// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, the icache, the hazard/branch logic and the IF/ID register.
// master = fetch unit side, slave = environment side.
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imemREN;
    logic [XLEN-1:0] imemaddr;
    logic            ihit;
    logic [XLEN-1:0] imemload;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_IF;
    logic [XLEN-1:0] next_pc_IF;
    logic            enable_IF_ID;
    logic            flush_IF_ID;
    logic            halted;
    logic            misalign_err;

    modport master (
        output imemREN, imemaddr, instruction, pc_IF, next_pc_IF,
               enable_IF_ID, flush_IF_ID, halted, misalign_err,
        input  ihit, imemload, stall, redirect, redirect_addr
    );

    modport slave (
        input  imemREN, imemaddr, instruction, pc_IF, next_pc_IF,
               enable_IF_ID, flush_IF_ID, halted, misalign_err,
        output ihit, imemload, stall, redirect, redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: PC ownership, icache requests, one-entry skid buffer and IF/ID load/flush control.
// Optional macro FETCH_ALIGN_CHECK_EN: force-align redirect targets and flag a sticky misalign_err.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPC = 6'b111111
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_unit_if.master  bus
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_LSB = 26;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] hold_instr, hold_instr_n;
    logic [XLEN-1:0] hold_pc, hold_pc_n;
    logic            halted_q;
    logic [XLEN-1:0] target;
    logic            load_is_halt;
    logic            hold_is_halt;
    logic            enable_c;
    logic            flush_c;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    assign target = {bus.redirect_addr[XLEN-1:2], 2'b00};

    // Sticky until reset: any misaligned redirect seen since reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            misalign_q <= 1'b0;
        end else if (bus.redirect && (bus.redirect_addr[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.misalign_err = misalign_q;
`else
    assign target           = bus.redirect_addr;
    assign bus.misalign_err = 1'b0;
`endif

    assign load_is_halt = (bus.imemload[XLEN-1:OPC_LSB] == HALT_OPC);
    assign hold_is_halt = (hold_instr[XLEN-1:OPC_LSB] == HALT_OPC);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            hold_instr <= '0;
            hold_pc    <= '0;
            halted_q   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
            halted_q   <= (state_n == HALTED);
        end
    end

    // Redirect overrides everything; otherwise FETCH/HOLD advance on ihit/stall.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        enable_c     = 1'b0;
        flush_c      = 1'b0;

        unique case (state)
            FETCH: begin
                if (bus.ihit) begin
                    if (!bus.stall) begin
                        enable_c = 1'b1;
                        if (load_is_halt) begin
                            state_n = HALTED;
                        end else begin
                            pc_n = pc + XLEN'(4);
                        end
                    end else begin
                        hold_instr_n = bus.imemload;
                        hold_pc_n    = pc;
                        pc_n         = pc + XLEN'(4);
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    enable_c = 1'b1;
                    state_n  = hold_is_halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        if (bus.redirect) begin
            flush_c  = 1'b1;
            enable_c = 1'b0;
            pc_n     = target;
            state_n  = FETCH;
        end
    end

    assign bus.imemREN      = (state == FETCH);
    assign bus.imemaddr     = pc;
    assign bus.instruction  = (state == HOLD) ? hold_instr : bus.imemload;
    assign bus.pc_IF        = (state == HOLD) ? hold_pc : pc;
    assign bus.next_pc_IF   = bus.pc_IF + XLEN'(4);
    assign bus.enable_IF_ID = enable_c;
    assign bus.flush_IF_ID  = flush_c;
    assign bus.halted       = halted_q;
endmodule
